// File: rtl/crc_serial_gen.sv
// Serial CRC generator: absorbs an Active-framed message LSB first, then shifts out
// the WIDTH-bit remainder LSB first and reseeds itself for the next message.
module crc_serial_gen #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h44),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(32'hD8)
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Data,
  input  logic Active,
  output logic Valid,
  output logic CRC,
  output logic Busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  // Top stage always takes the feedback bit, so its POLY bit is replaced by 1.
  localparam logic [WIDTH-1:0] TAPS = {1'b1, POLY[WIDTH-2:0]};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_OUT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] w_lfsr_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_crc;
  logic             w_crc_nxt;
  logic             r_busy;
  logic             w_busy_nxt;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s, input logic d);
    logic fb;
    fb = d ^ s[0];
    return (s >> 1) ^ ({WIDTH{fb}} & TAPS);
  endfunction

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_IDLE;
      r_lfsr  <= SEED;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_crc   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_crc   <= w_crc_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_valid;
    w_crc_nxt   = r_crc;
    w_busy_nxt  = r_busy;
    unique case (r_state)
      S_IDLE: begin
        if (Active) begin
          w_lfsr_nxt  = lfsr_step(r_lfsr, Data);
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (Active) begin
          w_lfsr_nxt = lfsr_step(r_lfsr, Data);
        end else begin
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_crc_nxt   = r_lfsr[0];
          w_lfsr_nxt  = r_lfsr >> 1;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        // Active and Data are deliberately ignored for the whole readout.
        if (r_cnt == CW'(WIDTH)) begin
          w_valid_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
          w_crc_nxt   = 1'b0;
          w_lfsr_nxt  = SEED;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_crc_nxt  = r_lfsr[0];
          w_lfsr_nxt = r_lfsr >> 1;
          w_cnt_nxt  = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign Valid = r_valid;
  assign CRC   = r_crc;
  assign Busy  = r_busy;

endmodule

// File: tb/tb_crc_serial_gen.sv
// Directed bench for crc_serial_gen: three instances (CRC-8 seed 0, CRC-8 seed D8,
// CRC-16 seed 0) sharing clock, reset and data, each with its own Active.
module tb_crc_serial_gen;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       data  = 1'b0;
  logic [2:0] act   = 3'b000;
  logic [2:0] vld;
  logic [2:0] crcb;
  logic [2:0] bsy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] msg;
    logic [7:0] crc;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  crc_serial_gen #(.WIDTH(8), .POLY(8'h44), .SEED(8'h00)) u_crc8_s0 (
    .Clk(clk), .Rst(rst_n), .Data(data), .Active(act[0]),
    .Valid(vld[0]), .CRC(crcb[0]), .Busy(bsy[0])
  );

  crc_serial_gen #(.WIDTH(8), .POLY(8'h44), .SEED(8'hD8)) u_crc8_sd8 (
    .Clk(clk), .Rst(rst_n), .Data(data), .Active(act[1]),
    .Valid(vld[1]), .CRC(crcb[1]), .Busy(bsy[1])
  );

  crc_serial_gen #(.WIDTH(16), .POLY(16'h1021), .SEED(16'h0000)) u_crc16_s0 (
    .Clk(clk), .Rst(rst_n), .Data(data), .Active(act[2]),
    .Valid(vld[2]), .CRC(crcb[2]), .Busy(bsy[2])
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp_v);
    end
  endtask

  // Called positioned at a falling edge; returns at the falling edge where Valid has dropped,
  // so a following call starts the next message at the minimum legal gap.
  task automatic run_msg(input string name, input int sel, input logic [31:0] msg,
                         input int nbits, input int width, input logic [31:0] exp_crc,
                         input bit pulse);
    logic [31:0] got;
    int          nvalid;
    int          nbusy_err;
    logic        first;
    logic        last_crc;
    got       = '0;
    nvalid    = 0;
    nbusy_err = 0;
    first     = 1'b0;
    last_crc  = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      act[sel] = 1'b1;
      data     = msg[i];
      @(negedge clk);
    end
    act[sel] = 1'b0;
    data     = 1'b0;
    for (int i = 0; i <= width; i++) begin
      @(negedge clk);
      if (i == 0) first = vld[sel];
      if (vld[sel] === 1'b1) begin
        if (nvalid < 32) got[nvalid] = crcb[sel];
        nvalid++;
      end
      if (bsy[sel] !== vld[sel]) nbusy_err++;
      last_crc = crcb[sel];
      if (pulse && i == 2) begin act[sel] = 1'b1; data = 1'b1; end
      if (pulse && i == 5) begin act[sel] = 1'b0; data = 1'b0; end
    end
    check({name, " latency"}, 32'(first), 32'd1);
    check({name, " valid_len"}, 32'(nvalid), 32'(width));
    check({name, " crc"}, got, exp_crc);
    check({name, " busy_eq_valid"}, 32'(nbusy_err), 32'd0);
    check({name, " crc_after"}, 32'(last_crc), 32'd0);
  endtask

  initial begin
    logic [2:0] seen;
    // Standard CRC-8 vectors, seed D8, poly 44, message 8 bits LSB first.
    vecs[0] = '{8'h00, 8'h14};
    vecs[1] = '{8'h01, 8'hBF};
    vecs[2] = '{8'h80, 8'hD0};
    vecs[3] = '{8'hFF, 8'h72};
    vecs[4] = '{8'hA5, 8'h7D};
    vecs[5] = '{8'h5A, 8'h1B};
    vecs[6] = '{8'h0F, 8'h39};
    vecs[7] = '{8'hF0, 8'h5F};
    vecs[8] = '{8'h55, 8'h36};
    vecs[9] = '{8'hAA, 8'h50};

    #12;
    check("reset_outputs", 32'({vld, crcb, bsy}), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    run_msg("seed0_msg01", 0, 32'h01, 8, 8, 32'hAB, 1'b0);

    // Back-to-back on the seed-D8 instance: each vector relies on the automatic reseed.
    for (int v = 0; v < 10; v++) begin
      run_msg($sformatf("vec%0d_%02h", v, vecs[v].msg), 1, 32'(vecs[v].msg), 8, 8,
              32'(vecs[v].crc), 1'b0);
    end

    // Active pulsed during readout must be ignored; second message at minimum gap.
    run_msg("b2b_first", 0, 32'h01, 8, 8, 32'hAB, 1'b1);
    run_msg("b2b_second", 0, 32'h01, 8, 8, 32'hAB, 1'b0);

    // Reset in the middle of readout.
    act[0] = 1'b1; data = 1'b1;
    @(negedge clk);
    data = 1'b0;
    for (int i = 1; i < 8; i++) @(negedge clk);
    act[0] = 1'b0;
    @(negedge clk);
    check("rst_mid bit0", 32'(crcb[0]), 32'd1);
    @(negedge clk);
    check("rst_mid bit1", 32'(crcb[0]), 32'd1);
    @(negedge clk);
    check("rst_mid bit2", 32'(crcb[0]), 32'd0);
    check("rst_mid valid_before", 32'(vld[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid async_drop", 32'({vld[0], crcb[0], bsy[0]}), 32'd0);
    seen = 3'b000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 seen = seen | {vld[0], crcb[0], bsy[0]};
    end
    check("rst_mid held_low", 32'(seen), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    seen = 3'b000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | {vld[0], crcb[0], bsy[0]};
    end
    check("rst_mid no_partial", 32'(seen), 32'd0);
    run_msg("after_rst_msg01", 0, 32'h01, 8, 8, 32'hAB, 1'b0);

    run_msg("w16_zero24", 2, 32'h0, 24, 16, 32'h0, 1'b0);
    run_msg("seed0_1bit0", 0, 32'h0, 1, 8, 32'h0, 1'b0);

    // No Active cycles: nothing must come out of any instance.
    seen = 3'b000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | vld | bsy;
    end
    check("idle_no_output", 32'(seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
